// File: rtl/systolic_host_pkg.sv
// Shared definitions for the systolic-array host sequencer: command opcodes,
// sequencer states and the default parameter set used by `top`.
package systolic_host_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'd0,
        OP_LOAD_B = 2'd1,
        OP_LOAD_I = 2'd2,
        OP_RUN    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_HOLD
    } state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_ROW_STRIDE = 256;
    localparam int DEF_INSTR_W    = 4;
    localparam int DEF_IADDR_W    = 3;
    localparam int DEF_OUT_W      = 32;
    localparam int DEF_OADDR_W    = 4;
    localparam int DEF_DIM_W      = 8;
    localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/stride_addr_gen.sv
// Row/column walker for matrix loads: produces row*ROW_STRIDE + col and flags
// the final element. With use_stride_i low it degenerates to a single row of
// cols_i elements (used for the instruction memory).
module stride_addr_gen #(
    parameter int DIM_W      = 8,
    parameter int ADDR_W     = 10,
    parameter int ROW_STRIDE = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic              use_stride_i,
    input  logic [DIM_W-1:0]  rows_i,
    input  logic [DIM_W-1:0]  cols_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    localparam int PW = 2 * DIM_W;

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic             col_last;
    logic [PW-1:0]    offs;

    // Next row/col, last-element flag and the strided address
    always_comb begin
        col_last = (col_q == cols_i - DIM_W'(1));
        last_o   = col_last && (!use_stride_i || (row_q == rows_i - DIM_W'(1)));
        row_d    = row_q;
        col_d    = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (step_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
        if (use_stride_i)
            offs = PW'(row_q) * PW'(ROW_STRIDE) + PW'(col_q);
        else
            offs = PW'(col_q);
        addr_o = offs[ADDR_W-1:0];
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/systolic_host_seq.sv
// Host-side sequencer for the systolic array: loads memA/memB/instruction
// memory from a word stream, runs the array with a done timeout and streams
// the output memory back over a valid/ready port.
module systolic_host_seq
    import systolic_host_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ROW_STRIDE = DEF_ROW_STRIDE,
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int IADDR_W    = DEF_IADDR_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int OADDR_W    = DEF_OADDR_W,
    parameter int DIM_W      = DEF_DIM_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DIM_W-1:0]   cmd_rows,
    input  logic [DIM_W-1:0]   cmd_cols,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [ADDR_W-1:0]  addrA,
    output logic [DATA_W-1:0]  dataA,
    output logic               enA,
    output logic [ADDR_W-1:0]  addrB,
    output logic [DATA_W-1:0]  dataB,
    output logic               enB,
    output logic [IADDR_W-1:0] addrI,
    output logic [INSTR_W-1:0] dataI,
    output logic               enI,
    output logic [OADDR_W-1:0] addrO,
    input  logic [OUT_W-1:0]   dataO,
    output logic               ap_start,
    input  logic               ap_done,
    output logic               busy,
    output logic               err_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = OADDR_W + 1;
    localparam int PW = 2 * DIM_W;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DIM_W-1:0]   rows_q, rows_d, cols_q, cols_d;
    logic               err_q, err_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic               cap_q, cap_d;
    logic               ov_q, ov_d;
    logic [OUT_W-1:0]   od_q, od_d;
    logic               en_a_q, en_a_d, en_b_q, en_b_d, en_i_q, en_i_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               alive_q;

    logic               cmd_fire, beat, zero_dim, rd_last;
    logic               gen_clr, gen_step, gen_last;
    logic [ADDR_W-1:0]  gen_addr;
    logic [PW-1:0]      n_total, n_beats;

    stride_addr_gen #(
        .DIM_W      (DIM_W),
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_gen (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (gen_clr),
        .step_i       (gen_step),
        .use_stride_i (op_q != OP_LOAD_I),
        .rows_i       (rows_q),
        .cols_i       (cols_q),
        .addr_o       (gen_addr),
        .last_o       (gen_last)
    );

    assign cmd_ready   = (state_q == S_IDLE) && alive_q;
    assign in_ready    = (state_q == S_LOAD);
    assign ap_start    = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign addrO       = k_q[OADDR_W-1:0];
    assign addrA       = waddr_q;
    assign dataA       = wdata_q;
    assign enA         = en_a_q;
    assign addrB       = waddr_q;
    assign dataB       = wdata_q;
    assign enB         = en_b_q;
    assign addrI       = waddr_q[IADDR_W-1:0];
    assign dataI       = wdata_q[INSTR_W-1:0];
    assign enI         = en_i_q;

    // Next-state logic, command capture, readback sequencing and write staging
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        cap_d    = cap_q;
        ov_d     = ov_q;
        od_d     = od_q;
        gen_clr  = 1'b0;
        gen_step = 1'b0;

        cmd_fire = cmd_valid && cmd_ready;
        beat     = (state_q == S_LOAD) && in_valid;
        // LOAD_I only looks at cols; every other op needs both dimensions
        zero_dim = (cmd_cols == '0) || ((cmd_rows == '0) && (op_e'(cmd_op) != OP_LOAD_I));
        n_total  = PW'(rows_q) * PW'(cols_q);
        n_beats  = (n_total > PW'(2 ** OADDR_W)) ? PW'(2 ** OADDR_W) : n_total;
        rd_last  = (PW'(k_q) + PW'(1)) == n_beats;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    op_d    = op_e'(cmd_op);
                    rows_d  = cmd_rows;
                    cols_d  = cmd_cols;
                    err_d   = 1'b0;
                    gen_clr = 1'b1;
                    if (zero_dim)
                        state_d = S_IDLE;
                    else if (op_e'(cmd_op) == OP_RUN)
                        state_d = S_START;
                    else
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    gen_step = 1'b1;
                    if (gen_last)
                        state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ap_done) begin
                    k_d     = '0;
                    state_d = S_READ;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_READ: begin
                cap_d   = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // First HOLD cycle is the memory read slot; valid follows it
                if (cap_q) begin
                    od_d  = dataO;
                    ov_d  = 1'b1;
                    cap_d = 1'b0;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    k_d     = k_q + KW'(1);
                    state_d = rd_last ? S_IDLE : S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_a_d  = beat && (op_q == OP_LOAD_A);
        en_b_d  = beat && (op_q == OP_LOAD_B);
        en_i_d  = beat && (op_q == OP_LOAD_I);
        waddr_d = beat ? gen_addr : waddr_q;
        wdata_d = beat ? in_data : wdata_q;
    end

    // State and datapath registers; reset clears every output immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD_A;
            rows_q  <= '0;
            cols_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            k_q     <= '0;
            cap_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            en_a_q  <= 1'b0;
            en_b_q  <= 1'b0;
            en_i_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            cap_q   <= cap_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            en_a_q  <= en_a_d;
            en_b_q  <= en_b_d;
            en_i_q  <= en_i_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            alive_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_host_seq.sv
// Scoreboard bench for systolic_host_seq: stimulus tasks push expected memory
// writes and readback words into queues; a negedge monitor pops and compares.
module tb_systolic_host_seq;
    import systolic_host_pkg::*;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 10;
    localparam int ROW_STRIDE = 256;
    localparam int INSTR_W    = 4;
    localparam int IADDR_W    = 3;
    localparam int OUT_W      = 32;
    localparam int OADDR_W    = 4;
    localparam int DIM_W      = 8;
    localparam int TIMEOUT    = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = '0;
    logic [DIM_W-1:0]   cmd_rows = '0, cmd_cols = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic [ADDR_W-1:0]  addrA, addrB;
    logic [DATA_W-1:0]  dataA, dataB;
    logic               enA, enB, enI;
    logic [IADDR_W-1:0] addrI;
    logic [INSTR_W-1:0] dataI;
    logic [OADDR_W-1:0] addrO;
    logic [OUT_W-1:0]   dataO = '0;
    logic               ap_start;
    logic               ap_done = 1'b0;
    logic               busy, err_timeout;

    systolic_host_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE),
        .INSTR_W(INSTR_W), .IADDR_W(IADDR_W), .OUT_W(OUT_W),
        .OADDR_W(OADDR_W), .DIM_W(DIM_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .addrA(addrA), .dataA(dataA), .enA(enA),
        .addrB(addrB), .dataB(dataB), .enB(enB),
        .addrI(addrI), .dataI(dataI), .enI(enI),
        .addrO(addrO), .dataO(dataO),
        .ap_start(ap_start), .ap_done(ap_done),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  kind;   // 0 memA, 1 memB, 2 instruction memory
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    int         n_vec  = 0;
    int         n_miss = 0;
    wr_t        wq[$];
    logic [OUT_W-1:0] oq[$];
    logic [OUT_W-1:0] memO [0:15];
    int         ready_mode = 0;
    int         rphase = 0;
    int         ap_cnt = 0;
    logic       prev_ap = 1'b0;
    logic       hold_v = 1'b0;
    logic [OUT_W-1:0] hold_d = '0;
    int         done_delay = -1;
    int         stub_cnt = 0;
    logic       stub_armed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_wr(input logic [7:0] kind, input logic [23:0] a, input logic [31:0] d);
        wr_t e;
        if (wq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_write: got kind %0d addr %0h data %0h, expected no write (t=%0t)",
                     kind, a, d, $time);
        end else begin
            e = wq.pop_front();
            chk("write", {kind, a, d}, e);
        end
    endtask

    // Stub of `top`: synchronous output-memory read, ap_done raised
    // done_delay cycles after ap_start and held until the next ap_start
    always @(posedge clk) dataO <= memO[addrO];

    always @(negedge clk) begin
        if (ap_start) begin
            ap_done    = 1'b0;
            stub_armed = (done_delay >= 0);
            stub_cnt   = done_delay;
        end
        if (stub_armed) begin
            if (stub_cnt == 0) begin
                ap_done    = 1'b1;
                stub_armed = 1'b0;
            end else begin
                stub_cnt--;
            end
        end
    end

    // Monitor: write ports, readback stream (with out_ready generation), ap_start width
    always @(negedge clk) begin
        if (enA) mon_wr(8'd0, 24'(addrA), 32'(dataA));
        if (enB) mon_wr(8'd1, 24'(addrB), 32'(dataB));
        if (enI) mon_wr(8'd2, 24'(addrI), 32'(dataI));

        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        rphase++;

        if (hold_v && !rst)
            chk("out_hold_stable", {31'd0, out_valid, out_data}, {31'd0, 1'b1, hold_d});
        hold_v = 1'b0;
        if (out_valid) begin
            if (out_ready) begin
                if (oq.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_out: got %0h, expected no beat (t=%0t)", out_data, $time);
                end else begin
                    chk("out_data", 64'(out_data), 64'(oq.pop_front()));
                end
            end else begin
                hold_v = 1'b1;
                hold_d = out_data;
            end
        end

        if (ap_start) begin
            ap_cnt++;
            if (prev_ap) chk("ap_start_width", 64'(2), 64'(1));
        end
        prev_ap = ap_start;
    end

    task automatic send_cmd(input int op, input int rows, input int cols);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_rows  = DIM_W'(rows);
        cmd_cols  = DIM_W'(cols);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_cleared_on_accept", 64'(err_timeout), 64'(0));
    endtask

    // dmode: 0 random data, 1 banded ones, 2 {4,0,...}, 3 random data with in_valid held high
    task automatic do_load(input int op, input int rows, input int cols, input int dmode, input int stop_after);
        int total = (op == 2) ? cols : rows * cols;
        int idx = 0;
        int t = 0;
        int r, c;
        logic v;
        logic [DATA_W-1:0] d;
        wr_t e;
        send_cmd(op, rows, cols);
        if (total == 0) begin
            chk("zero_dim_idle", {62'd0, busy, cmd_ready}, 64'b01);
            return;
        end
        chk("in_ready_latency", 64'(in_ready), 64'(1));
        while (idx < total && !(stop_after > 0 && idx == stop_after) && t < 5000) begin
            r = (op == 2) ? 0 : idx / cols;
            c = (op == 2) ? idx : idx % cols;
            v = (dmode == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (dmode)
                1:       d = (c >= r && c <= r + 3) ? DATA_W'(1) : '0;
                2:       d = (idx == 0) ? DATA_W'(4) : '0;
                default: d = DATA_W'($urandom);
            endcase
            in_valid = v;
            in_data  = d;
            if (v && in_ready) begin
                e.kind = 8'(op);
                e.addr = (op == 2) ? 24'(idx % (1 << IADDR_W))
                                   : 24'((r * ROW_STRIDE + c) % (1 << ADDR_W));
                e.data = (op == 2) ? 32'(d & DATA_W'((1 << INSTR_W) - 1)) : 32'(d);
                wq.push_back(e);
                idx++;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (stop_after == 0 && idx < total) chk("load_beats", 64'(idx), 64'(total));
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(cmd_ready && wq.size() == 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, {62'd0, cmd_ready, (wq.size() == 0)}, 64'b11);
    endtask

    // delay < 0: ap_done never arrives
    task automatic do_run(input int rows, input int cols, input int delay);
        int n = rows * cols;
        int a0;
        int t = 0;
        if (n > (1 << OADDR_W)) n = 1 << OADDR_W;
        done_delay = delay;
        for (int i = 0; i < 16; i++) memO[i] = OUT_W'($urandom);
        if (delay >= 0)
            for (int k = 0; k < n; k++) oq.push_back(memO[k]);
        a0 = ap_cnt;
        send_cmd(3, rows, cols);
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("run_done_all_beats", {31'd0, cmd_ready, 32'(oq.size())}, {31'd0, 1'b1, 32'd0});
        chk("ap_start_count", 64'(ap_cnt - a0), 64'((n == 0) ? 0 : 1));
        chk("err_timeout", 64'(err_timeout), 64'((delay < 0 && n > 0) ? 1 : 0));
        if (delay < 0 && n > 0) chk("timeout_cycles", 64'(t), 64'(TIMEOUT + 1));
        oq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // reset values
        #3;
        chk("reset_outputs_zero",
            64'(|{cmd_ready, in_ready, out_valid, out_data, addrA, dataA, enA, addrB, dataB, enB,
                  addrI, dataI, enI, addrO, ap_start, busy, err_timeout}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, cmd_ready, busy}, 64'b10);

        // banded LOAD_A 4x7, then instruction load
        do_load(0, 4, 7, 1, 0);
        wait_idle("loadA_banded_done");
        do_load(2, 1, 8, 2, 0);
        wait_idle("loadI_done");

        // RUN with done after 20 cycles, then with toggling out_ready
        ready_mode = 0;
        do_run(4, 4, 20);
        ready_mode = 1;
        do_run(4, 4, 5);

        // timeout, then a command that clears the sticky error
        ready_mode = 0;
        do_run(4, 4, -1);
        do_load(1, 2, 3, 0, 0);
        wait_idle("loadB_after_timeout");

        // zero dimensions
        do_load(0, 0, 5, 0, 0);
        do_load(2, 1, 0, 0, 0);
        do_run(3, 0, 0);

        // reset during a LOAD_B after 10 beats
        do_load(1, 4, 7, 3, 10);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy_drained", {31'd0, busy, 32'(wq.size())}, {31'd0, 1'b1, 32'd0});
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs_zero",
            64'(|{cmd_ready, in_ready, out_valid, out_data, addrA, dataA, enA, addrB, dataB, enB,
                  addrI, dataI, enI, addrO, ap_start, busy, err_timeout}), 64'(0));
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_reset_no_enB", {62'd0, enB, busy}, 64'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_load(1, 4, 7, 0, 0);
        wait_idle("loadB_after_reset");

        // randomized mix
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                int op = $urandom_range(0, 2);
                do_load(op, $urandom_range(1, 5), $urandom_range(1, 12), 0, 0);
                wait_idle("rand_load_done");
            end else begin
                ready_mode = 2;
                do_run($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, 30));
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/systolic_host_seq.md
# systolic_host_seq

Synthesizable host-side sequencer for the systolic array `top`: it performs, in hardware, the load/start/readback sequence that is currently done by hand in simulation. It accepts commands plus a valid/ready input word stream, and writes row-major matrices into memA/memB with a configurable row stride. It also loads instruction memory, pulses `ap_start`, waits for `ap_done` with a timeout, and streams the output memory back out over a valid/ready port. It is parametrised in data width, address widths, row stride and timeout, and sits between a host bus bridge and `top`.

## Interface
- `DATA_W`, 16, matrix word width (dataA/dataB)
- `ADDR_W`, 10, memA/memB address width
- `ROW_STRIDE`, 256, address distance between matrix rows
- `INSTR_W`, 4, instruction word width
- `IADDR_W`, 3, instruction address width
- `OUT_W`, 32, result word width
- `OADDR_W`, 4, output memory address width
- `DIM_W`, 8, width of the row/column count fields
- `TIMEOUT`, 1024, maximum WAIT cycles before abort
- `clk` in 1: the single clock; everything is on the rising edge
- `rst` in 1: reset, asynchronous and active-high
- `cmd_valid` / `cmd_ready` in/out 1: command handshake
- `cmd_op` in 2: 0 LOAD_A, 1 LOAD_B, 2 LOAD_I, 3 RUN
- `cmd_rows`, `cmd_cols` in DIM_W: matrix dimensions
- `in_valid` / `in_ready` in/out 1, `in_data` in DATA_W: load stream; LOAD_I uses the low INSTR_W bits
- `out_valid` / `out_ready` out/in 1, `out_data` out OUT_W: readback stream
- `addrA`/`dataA`/`enA`, `addrB`/`dataB`/`enB`: out ADDR_W/DATA_W/1, matrix write ports
- `addrI`/`dataI`/`enI`: out IADDR_W/INSTR_W/1, instruction write port
- `addrO` out OADDR_W, `dataO` in OUT_W: output memory read port
- `ap_start` out 1, `ap_done` in 1: run handshake with `top`
- `busy` out 1, `err_timeout` out 1: status

## Operation
- States: IDLE, LOAD, START, WAIT, READ, HOLD.
- **IDLE**
  - `cmd_ready` = 1. A command is accepted on `cmd_valid && cmd_ready`.
  - On accept, the op, rows and cols are latched and `err_timeout` is cleared.
- **LOAD (LOAD_A / LOAD_B)**
  - `in_ready` = 1. Each accepted beat writes `in_data` to address `row*ROW_STRIDE + col` (truncated to ADDR_W).
  - `col` counts 0..cols-1 and wraps; `row` then increments.
  - After beat (rows-1, cols-1) the block returns to IDLE. Total beats = rows*cols.
- **LOAD (LOAD_I)**
  - `rows` is ignored. `cols` beats are written to addrI 0..cols-1.
  - Addresses wrap modulo 2^IADDR_W.
- **RUN**
  - START: `ap_start` = 1 for exactly one cycle, then WAIT.
  - WAIT: the cycle counter increments each cycle.
    - `ap_done` = 1 → READ with k = 0.
    - Counter reaches TIMEOUT → `err_timeout` = 1 (sticky until the next accepted command), back to IDLE, no readback.
  - READ: drive `addrO` = k, then HOLD.
  - HOLD: `out_data` = `dataO` captured one cycle after `addrO`. `out_valid` is held until `out_ready`.
    - On accept, k increments.
    - When k reaches N = min(rows*cols, 2^OADDR_W) → IDLE; otherwise → READ.
- Zero rows or cols on any op completes immediately: no writes, no `ap_start`, back to IDLE.
- `in_valid` outside LOAD is ignored. `in_ready` = 0 in every state except LOAD.
- `busy` = (state != IDLE).

## Timing
- Reset values (all outputs): 0. State = IDLE, all counters = 0.
- Reset mid-operation aborts immediately: no further writes, and a pending `out_valid` is dropped.
- Command accept to first `in_ready`: 1 cycle.
- Write latency:
  - An input beat accepted in cycle t produces `en*` = 1 in cycle t+1, with address and data registered.
  - `en*` is a single-cycle pulse per beat. Back-to-back beats give back-to-back pulses.
- After the last beat's write pulse, `cmd_ready` rises in the same cycle.
- `ap_done` is sampled only in WAIT. If `ap_done` is already high in the first WAIT cycle, that counts as done.
- Readback issue to `out_valid`:
  - `addrO` is driven in READ (cycle r).
  - `dataO` is captured at the end of r+1.
  - `out_valid` = 1 from r+2.
- Readback throughput: one result per 3 cycles maximum, with one read outstanding.
- Timeout abort: `err_timeout` rises at the end of the TIMEOUT-th WAIT cycle, and `cmd_ready` is 1 in the next cycle.
- Row/column counters are DIM_W wide. Products use 2*DIM_W bits before truncation.

## Structure
- Package `systolic_host_pkg` holds:
  - op encodings (`OP_LOAD_A`, `OP_LOAD_B`, `OP_LOAD_I`, `OP_RUN`)
  - the state enum
  - default parameter constants shared with `top`
- Sub-module `stride_addr_gen`: a row/col counter with wrap and last flag, producing `row*ROW_STRIDE + col`. It is reused for LOAD_A, LOAD_B and LOAD_I (with stride 0).

## Test plan
- **LOAD_A** rows=4, cols=7, banded-ones data → 28 `enA` pulses at addrs 0–6, 256–262, 512–518, 768–774; data 1 at (i, i..i+3), else 0.
- **LOAD_I** cols=8, data {4,0,0,0,0,0,0,0} → `enI` pulses at addrI 0..7, with `dataI` = 4 at addr 0 and 0 elsewhere.
- **RUN** rows=4, cols=4, stub raises `ap_done` 20 cycles after `ap_start` → one-cycle `ap_start`; 16 `out_data` beats matching the stub output memory at addrO 0..15; `cmd_ready` only after the last beat.
- **Readback with `out_ready` toggling** 1,0,0,1 … → no beat lost or duplicated; `out_data` stable while `out_valid && !out_ready`.
- **RUN with TIMEOUT = 64** and no `ap_done` → `err_timeout` = 1 after 64 WAIT cycles, zero out beats, next command accepted and `err_timeout` cleared.
- **`rst` asserted after 10 beats of a 4×7 LOAD_B** → all outputs 0 asynchronously, no further `enB`; a following LOAD_B restarts at addr 0.
